// File: rtl/divider.sv
// RV32M divide unit: DIV/DIVU/REM/REMU, restoring radix-2, one bit per cycle.
// Ports: clk, rst_n, valid/opcode/rd_idx/ra_operand/rb_operand in, hold stall;
//        busy, wb_valid, wb_rd_idx, wb_value out.
module divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid,
   input  logic [31:0]     opcode,
   input  logic [4:0]      rd_idx,
   input  logic [XLEN-1:0] ra_operand,
   input  logic [XLEN-1:0] rb_operand,
   input  logic            hold,
   output logic            busy,
   output logic            wb_valid,
   output logic [4:0]      wb_rd_idx,
   output logic [XLEN-1:0] wb_value
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e          state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            is_rem_q, is_rem_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] wbv_q, wbv_d;
   logic [4:0]      wbrd_q, wbrd_d;

   logic            is_div, f_rem, f_sgn;
   logic            a_neg, b_neg, div0, ovf;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   rem_sh, rem_nx, rem_neg;
   logic [XLEN+1:0] diff;
   logic            ge;
   logic [XLEN-1:0] quo_nx, q_fix, r_fix;

   assign is_div = valid && (opcode[6:0] == 7'b0110011)
                && (opcode[31:25] == 7'b0000001) && opcode[14];
   assign f_rem  = opcode[13];
   assign f_sgn  = ~opcode[12];
   assign a_neg  = f_sgn & ra_operand[XLEN-1];
   assign b_neg  = f_sgn & rb_operand[XLEN-1];
   // 0x80000000 negates to itself, which is the correct unsigned magnitude
   assign a_mag  = a_neg ? (~ra_operand + 1'b1) : ra_operand;
   assign b_mag  = b_neg ? (~rb_operand + 1'b1) : rb_operand;
   assign div0   = (rb_operand == '0);
   assign ovf    = f_sgn && (ra_operand == {1'b1, {(XLEN-1){1'b0}}})
                && (rb_operand == '1);

   // one restoring step: shift in next dividend bit, trial subtract
   assign rem_sh  = {rem_q[XLEN-1:0], dvd_q[XLEN-1]};
   assign diff    = {1'b0, rem_sh} - {2'b00, dvs_q};
   assign ge      = ~diff[XLEN+1];
   assign rem_nx  = ge ? diff[XLEN:0] : rem_sh;
   assign quo_nx  = {quo_q[XLEN-2:0], ge};
   assign rem_neg = ~rem_nx + 1'b1;
   assign q_fix   = negq_q ? (~quo_nx + 1'b1) : quo_nx;
   assign r_fix   = negr_q ? rem_neg[XLEN-1:0] : rem_nx[XLEN-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_rem_d = is_rem_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      rd_d     = rd_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      wbv_d    = wbv_q;
      wbrd_d   = wbrd_q;
      if (!hold) begin
         unique case (state_q)
            IDLE: begin
               if (is_div) begin
                  is_rem_d = f_rem;
                  rd_d     = rd_idx;
                  dvd_d    = a_mag;
                  dvs_d    = b_mag;
                  negq_d   = a_neg ^ b_neg;
                  negr_d   = a_neg;
                  rem_d    = '0;
                  quo_d    = '0;
                  cnt_d    = '0;
                  if (div0 || ovf) begin
                     state_d = DONE;
                     wbrd_d  = rd_idx;
                     // div0: q=-1, r=a; overflow: q=a (0x80000000), r=0
                     if (div0) wbv_d = f_rem ? ra_operand : '1;
                     else      wbv_d = f_rem ? '0 : ra_operand;
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               cnt_d = cnt_q + 5'd1;
               rem_d = rem_nx;
               quo_d = quo_nx;
               dvd_d = dvd_q << 1;
               if (cnt_q == 5'd31) begin
                  state_d = DONE;
                  wbrd_d  = rd_q;
                  wbv_d   = is_rem_q ? r_fix : q_fix;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_rem_q <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         rd_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         wbv_q    <= '0;
         wbrd_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_rem_q <= is_rem_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         rd_q     <= rd_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         wbv_q    <= wbv_d;
         wbrd_q   <= wbrd_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign wb_valid  = (state_q == DONE);
   assign wb_value  = wbv_q;
   assign wb_rd_idx = wbrd_q;

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: XLEN, 32, operand and result width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: valid  input  1  opcode and operands are valid this cycle.
REQ-005 Port: opcode  input  32  full RV32 instruction word.
REQ-006 Port: rd_idx  input  5  destination register index.
REQ-007 Port: ra_operand  input  32  rs1 value (dividend).
REQ-008 Port: rb_operand  input  32  rs2 value (divisor).
REQ-009 Port: hold  input  1  pipeline stall; freezes all block state.
REQ-010 Port: busy  output  1  a division is in progress or its result is not yet consumed.
REQ-011 Port: wb_valid  output  1  wb_value and wb_rd_idx are valid.
REQ-012 Port: wb_rd_idx  output  5  destination index of the completed operation.
REQ-013 Port: wb_value  output  32  quotient or remainder.

Function
REQ-014 Decode: opcode[6:0]=0110011 and funct7=0000001 SHALL qualify a division. funct3 SHALL select the operation: 100 DIV, 101 DIVU, 110 REM, 111 REMU. All other encodings SHALL be ignored.
REQ-015 States SHALL be IDLE, CALC and DONE. busy SHALL be 1 whenever the state is not IDLE.
REQ-016 Accept: in IDLE with valid=1, a division decode and hold=0, the block SHALL capture the operation type, rd_idx, operand magnitudes and sign flags.
- Normal case: next state CALC, step counter=0.
- Special case: next state DONE.
REQ-017 While busy=1, valid, opcode and operands SHALL be ignored. No queuing takes place.
REQ-018 CALC SHALL perform one restoring radix-2 step per cycle on unsigned magnitudes (33-bit partial remainder). After step 31 (32 steps) the next state SHALL be DONE.
REQ-019 Signed ops: operand magnitudes SHALL be taken as two's-complement absolute values.
- Quotient negated iff the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-020 Divide by zero:
- DIV/DIVU: result 0xFFFFFFFF.
- REM/REMU: result = dividend.
- Enters DONE the cycle after accept.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF):
- DIV: result 0x80000000.
- REM: result 0x00000000.
- Enters DONE the cycle after accept.
REQ-022 In DONE: wb_valid=1, with wb_value and wb_rd_idx stable. The first cycle in DONE with hold=0 is the consume cycle; on the following edge the state SHALL return to IDLE.
REQ-023 The block SHALL NOT accept a new operation in the same cycle it leaves DONE.
REQ-024 Latency (accept edge = cycle 0, hold=0 throughout):
- Normal ops: wb_valid=1 in cycle 33.
- Special cases: wb_valid=1 in cycle 1.
REQ-025 hold=1 SHALL freeze state, counter, partial remainder, quotient and all outputs, in every state.
REQ-026 wb_valid SHALL be 0 in IDLE and CALC. wb_value and wb_rd_idx SHALL hold their last values while wb_valid=0.
REQ-027 Results SHALL be exact 32-bit values. No intermediate may be truncated below 33 bits before sign fix-up.

Reset
REQ-028 rst_n=0 SHALL asynchronously force:
- State IDLE, counter 0.
- busy=0, wb_valid=0, wb_value=0, wb_rd_idx=0.
- All datapath registers to 0.
REQ-029 Reset asserted mid-CALC or in DONE SHALL abort the operation with no result produced.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept an operation.

Verification
REQ-031 DIVU 100/7, rd=5 -> busy=1 from cycle 1; wb_valid=1 in cycle 33; wb_value=14, wb_rd_idx=5; IDLE after consume.
REQ-032 DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REMU 0xFFFFFFF9/2 -> 1.
REQ-033 DIV 5/0 -> 0xFFFFFFFF in cycle 1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
REQ-034 hold=1 for 4 cycles mid-CALC -> wb_valid delayed exactly 4 cycles, result unchanged. hold=1 in DONE -> wb_valid stays 1 until hold falls.
REQ-035 New valid DIV presented while busy -> ignored; only the first result appears; the block returns to IDLE.
REQ-036 rst_n pulsed low in CALC step 10 -> busy=0 and wb_valid=0 immediately; no wb_valid pulse follows; a fresh DIVU 9/3 afterwards -> 3.
